// File: rtl/mul_job_sequencer.sv
// Job front-end for the repeated-addition multiplier: accepts operands,
// launches and feeds the controller, returns the product, then restarts it.
//
// Parameters:
//   W        operand width (product is 2*W)
//   CLR_CYC  cycles mul_clr is held during restart (>=1)
//   TMO      watchdog limit in cycles (0 = off), only with MUL_TIMEOUT_EN
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_a/in_b       operand port
//   out_valid/out_ready/out_p/out_err result port
//   mul_start, mul_clr, mul_data      controls and data_in bus to multiplier
//   mul_ldA, mul_ldB, mul_done, mul_prod  strobes and P register from it
// Optional feature: define MUL_TIMEOUT_EN to build the watchdog.
module mul_job_sequencer #(
  parameter int W       = 16,
  parameter int CLR_CYC = 2,
  parameter int TMO     = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           out_err,
  output logic           mul_start,
  output logic           mul_clr,
  output logic [W-1:0]   mul_data,
  input  logic           mul_ldA,
  input  logic           mul_ldB,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_prod
);

  localparam int CW =
    (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CW-1:0] CLR_LAST =
    CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_LAUNCH,
    S_FEED,
    S_WAIT,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t state, state_n;

  logic [W-1:0]   a_r, b_r;
  logic [2*W-1:0] p_r;
  logic           err_r;
  logic [CW-1:0]  rcnt;
  logic           accept;
  logic           take_done;
  logic           tmo_hit;

  assign accept = (state == S_IDLE) && in_valid;

  // done is only trusted once ldB has been seen,
  // either earlier (WAIT) or in this same cycle.
  assign take_done = mul_done &&
    ((state == S_WAIT) ||
     ((state == S_FEED) && mul_ldB));

`ifdef MUL_TIMEOUT_EN
  logic [31:0] wd;
  logic        busy;

  assign busy = (state == S_LAUNCH) ||
                (state == S_FEED) ||
                (state == S_WAIT);

  assign tmo_hit = (TMO != 0) && busy &&
    (wd == 32'(TMO - 1)) && !take_done;

  always_ff @(posedge clk) begin
    if (!rst_n) wd <= '0;
    else if (busy) wd <= wd + 32'd1;
    else wd <= '0;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RST;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RST: state_n = S_RECOVER;
      S_IDLE:
        if (in_valid)
          state_n = (in_b == '0) ? S_HOLD
                                 : S_LAUNCH;
      S_LAUNCH:
        state_n = tmo_hit ? S_HOLD : S_FEED;
      S_FEED:
        if (take_done || tmo_hit)
          state_n = S_HOLD;
        else if (mul_ldB)
          state_n = S_WAIT;
      S_WAIT:
        if (take_done || tmo_hit)
          state_n = S_HOLD;
      S_HOLD:
        if (out_ready) state_n = S_RECOVER;
      S_RECOVER:
        if (rcnt == CLR_LAST) state_n = S_IDLE;
      default: state_n = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      p_r   <= '0;
      err_r <= 1'b0;
      rcnt  <= '0;
    end else begin
      if (accept) begin
        a_r <= in_a;
        b_r <= in_b;
      end
      if (accept && (in_b == '0)) begin
        p_r   <= '0;
        err_r <= 1'b0;
      end else if (take_done) begin
        p_r   <= mul_prod;
        err_r <= 1'b0;
      end else if (tmo_hit) begin
        p_r   <= '0;
        err_r <= 1'b1;
      end else if ((state == S_HOLD) && out_ready) begin
        err_r <= 1'b0;
      end
      if (state == S_RECOVER) rcnt <= rcnt + 1'b1;
      else rcnt <= '0;
    end
  end

  // Ready is shown while reset is held, but drops in the
  // release cycle so an offered pair is never silently lost.
  assign in_ready = (state == S_IDLE) ||
                    ((state == S_RST) && !rst_n);

  assign out_valid = (state == S_HOLD);
  assign out_p     = p_r;
  assign out_err   = err_r;
  assign mul_start = (state == S_LAUNCH);
  assign mul_clr   = (state == S_RST) ||
                     (state == S_RECOVER);
  assign mul_data  = mul_ldB ? b_r : a_r;

endmodule
